strobe_rx_mux: RTL and testbench

Multi-channel, single-clock receiver for toggle-style clock-crossing strobes from foreign domains. Each of NCH channels carries a toggle line plus a data bus held stable by the source between toggles. The block synchronises each toggle and detects each change as one event. On each event it captures the channel data into a per-channel FIFO, then merges all channels round-robin onto one valid/ready stream tagged with the channel number.

---
 rtl/strobe_rx_mux_pkg.sv | 18 +
 rtl/strobe_rx_fifo.sv | 50 +++++
 rtl/strobe_rx_mux.sv | 137 +++++++++++++
 tb/tb_strobe_rx_mux.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/strobe_rx_mux_pkg.sv
// Shared helpers for the strobe receiver: ceiling log2 and channel-tag width.
package strobe_rx_mux_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // A single channel still needs a one-bit tag.
   function automatic int chan_w(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/strobe_rx_fifo.sv
// Per-channel capture FIFO, WIDTH x DEPTH; head visible combinationally on pop_dat.
// A push into a full FIFO is accepted only when the same cycle pops, otherwise dropped.
module strobe_rx_fifo
   import strobe_rx_mux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_dat,
   output logic                     full,
   output logic                     empty,
   output logic [clog2(DEPTH):0]    count
);
   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign wr_en   = push && (!full || pop);
   assign rd_en   = pop && !empty;
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && !rd_en)      count <= count + 1'b1;
         else if (!wr_en && rd_en) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/strobe_rx_mux.sv
// Toggle-strobe receiver: sync, edge-detect, per-channel FIFO, round-robin merge to one stream.
// Event strobes DELAY+1 cycles after a toggle; output is a registered beat held until out_ready.
module strobe_rx_mux
   import strobe_rx_mux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int DELAY = 2,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NCH-1:0]           toggle_in,
   input  logic [NCH*WIDTH-1:0]     data_in,
   output logic [NCH-1:0]           strobe_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [chan_w(NCH)-1:0]   out_chan,
   output logic [NCH-1:0]           overflow,
   input  logic                     ovf_clear
);
   localparam int CW = chan_w(NCH);
   localparam int AW = clog2(DEPTH);
   localparam int WW = clog2(DELAY + 2);

   if (DELAY < 2) begin : g_bad_delay
      $error("strobe_rx_mux: DELAY must be at least 2");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("strobe_rx_mux: DEPTH must be a power of 2, at least 2");
   end
   if (NCH < 1 || NCH > 16) begin : g_bad_nch
      $error("strobe_rx_mux: NCH must be 1..16");
   end

   logic [DELAY-1:0] sync_q [NCH];
   logic [NCH-1:0]   sync_out;
   logic [NCH-1:0]   last_q;
   logic [WW-1:0]    warm_q;
   logic             warm_done;
   logic [NCH-1:0]   event_v;
   logic [NCH-1:0]   full_v;
   logic [NCH-1:0]   empty_v;
   logic [NCH-1:0]   pop_v;
   logic [NCH-1:0]   drop_v;
   logic [WIDTH-1:0] head [NCH];
   logic [AW:0]      fifo_cnt [NCH];
   logic [CW-1:0]    rr_q;
   logic [CW-1:0]    grant;
   logic [CW-1:0]    rr_next;
   logic             found;
   logic             load;

   always_comb begin
      sync_out = '0;
      for (int k = 0; k < NCH; k++) sync_out[k] = sync_q[k][DELAY-1];
   end

   // Until the last-level regs have caught up with the synchronisers, level differences are not events.
   assign warm_done = (warm_q == WW'(DELAY + 1));
   assign event_v   = (sync_out ^ last_q) & {NCH{warm_done}};
   assign drop_v    = event_v & full_v & ~pop_v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NCH; k++) sync_q[k] <= '0;
         last_q     <= '0;
         warm_q     <= '0;
         strobe_out <= '0;
         overflow   <= '0;
      end else begin
         for (int k = 0; k < NCH; k++) sync_q[k] <= {sync_q[k][DELAY-2:0], toggle_in[k]};
         last_q     <= sync_out;
         if (!warm_done) warm_q <= warm_q + 1'b1;
         strobe_out <= event_v;
         overflow   <= (ovf_clear ? '0 : overflow) | drop_v;
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      strobe_rx_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk      (clk),
         .rst_n    (rst_n),
         .push     (event_v[k]),
         .push_dat (data_in[k*WIDTH +: WIDTH]),
         .pop      (pop_v[k]),
         .pop_dat  (head[k]),
         .full     (full_v[k]),
         .empty    (empty_v[k]),
         .count    (fifo_cnt[k])
      );

      a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
         pop_v[k] |-> fifo_cnt[k] != '0);
   end

   // Round-robin: first non-empty channel at or after the pointer wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (!found && !empty_v[(int'(rr_q) + i) % NCH]) begin
            found = 1'b1;
            grant = CW'((int'(rr_q) + i) % NCH);
         end
      end
   end

   assign load    = (!out_valid || out_ready) && found;
   assign rr_next = (int'(grant) == NCH - 1) ? '0 : grant + 1'b1;

   always_comb begin
      pop_v = '0;
      if (load) pop_v[grant] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         rr_q      <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= head[grant];
         out_chan  <= grant;
         rr_q      <= rr_next;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_strobe_rx_mux.sv
// Directed bench for strobe_rx_mux with DELAY=2, WIDTH=8, NCH=4, DEPTH=4.
module tb_strobe_rx_mux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  toggle_in;
   logic [31:0] data_in;
   logic [3:0]  strobe_out;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_chan;
   logic [3:0]  overflow;
   logic        ovf_clear;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   strobe_rx_mux #(
      .WIDTH (8),
      .NCH   (4),
      .DELAY (2),
      .DEPTH (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .toggle_in  (toggle_in),
      .data_in    (data_in),
      .strobe_out (strobe_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_chan   (out_chan),
      .overflow   (overflow),
      .ovf_clear  (ovf_clear)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic flip(input int k, input logic [7:0] d);
      data_in[k*8 +: 8] = d;
      toggle_in[k]      = ~toggle_in[k];
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(10);
   endtask

   logic [1:0] rr_chan [6];
   logic [7:0] rr_data [6];

   initial begin
      rst_n     = 1'b0;
      toggle_in = 4'b1010;
      data_in   = '0;
      out_ready = 1'b1;
      ovf_clear = 1'b0;
      rr_chan   = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3};
      rr_data   = '{8'h20, 8'h30, 8'h21, 8'h31, 8'h22, 8'h32};

      // Reset state, then idle with toggles already high.
      cyc(3);
      check("rst_valid", out_valid, 0);
      check("rst_strobe", strobe_out, 0);
      check("rst_ovf", overflow, 0);
      check("rst_data", out_data, 0);
      check("rst_chan", out_chan, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         check("idle_strobe", strobe_out, 0);
         check("idle_valid", out_valid, 0);
      end

      // All four channels at once: beats in channel order.
      for (int k = 0; k < 4; k++) flip(k, 8'h10 + 8'(k));
      cyc(2);
      check("all_strobe_e2", strobe_out, 4'h0);
      cyc(1);
      check("all_strobe_e3", strobe_out, 4'hF);
      check("all_valid_e3", out_valid, 0);
      for (int k = 0; k < 4; k++) begin
         cyc(1);
         check("all_valid", out_valid, 1);
         check("all_data", out_data, 32'h10 + 32'(k));
         check("all_chan", out_chan, 32'(k));
      end
      cyc(1);
      check("all_drain", out_valid, 0);

      // Single event on ch2: strobe after E3, beat after E4.
      flip(2, 8'hA5);
      cyc(2);
      check("c2_strobe_e2", strobe_out, 4'h0);
      cyc(1);
      check("c2_strobe_e3", strobe_out, 4'b0100);
      check("c2_valid_e3", out_valid, 0);
      cyc(1);
      check("c2_strobe_e4", strobe_out, 4'h0);
      check("c2_valid_e4", out_valid, 1);
      check("c2_data", out_data, 8'hA5);
      check("c2_chan", out_chan, 2);
      cyc(1);
      check("c2_valid_e5", out_valid, 0);
      check("c2_data_hold", out_data, 8'hA5);
      check("c2_chan_hold", out_chan, 2);

      // Backpressure on ch1: six events, one held, four queued, one dropped.
      out_ready = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         flip(1, 8'(i));
         cyc(3);
         check("ovf_strobe", strobe_out, 4'b0010);
         cyc(2);
         check("ovf_hold_data", out_data, 1);
      end
      check("ovf_flag", overflow, 4'b0010);
      check("ovf_valid", out_valid, 1);
      check("ovf_chan", out_chan, 1);
      out_ready = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         check("ovf_beat_valid", out_valid, 1);
         check("ovf_beat_data", out_data, 32'(e));
         check("ovf_beat_chan", out_chan, 1);
         cyc(1);
      end
      check("ovf_drain", out_valid, 0);
      check("ovf_sticky", overflow, 4'b0010);
      ovf_clear = 1'b1;
      cyc(1);
      ovf_clear = 1'b0;
      check("ovf_cleared", overflow, 0);

      // Round-robin between ch0 and ch3 from a fresh pointer.
      do_reset();
      out_ready = 1'b0;
      for (int r = 0; r < 3; r++) begin
         flip(0, 8'h20 + 8'(r));
         flip(3, 8'h30 + 8'(r));
         cyc(4);
      end
      cyc(2);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check("rr_valid", out_valid, 1);
         check("rr_chan", out_chan, rr_chan[i]);
         check("rr_data", out_data, rr_data[i]);
         cyc(1);
      end
      check("rr_drain", out_valid, 0);
      check("rr_ovf", overflow, 0);

      // Asynchronous reset with beats queued and an overflow pending.
      out_ready = 1'b0;
      for (int r = 1; r <= 6; r++) begin
         flip(2, 8'h40 + 8'(r));
         cyc(4);
      end
      cyc(2);
      check("mr_valid_pre", out_valid, 1);
      check("mr_data_pre", out_data, 8'h41);
      check("mr_ovf_pre", overflow, 4'b0100);
      flip(0, 8'h77);
      cyc(3);
      check("mr_strobe_pre", strobe_out, 4'b0001);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_valid", out_valid, 0);
      check("mr_strobe", strobe_out, 0);
      check("mr_ovf", overflow, 0);
      check("mr_data", out_data, 0);
      flip(1, 8'h55);
      cyc(2);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         check("mr_post_strobe", strobe_out, 0);
         check("mr_post_valid", out_valid, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
